axi_line_bridge: RTL

- Slave end of the cache-line bus between the I/D caches and the SoC AXI port: implements the axi-module side of AXI_Bus_Interface.
- Converts one 128-bit line refill (rd_req) into a 4-beat AXI4 INCR read burst.
- Converts one 128-bit line writeback (wr_req) into a 4-beat AXI4 INCR write burst.
- Read and write paths are independent FSMs sharing one AXI master port.
- One clock; reset is asynchronous and active-low.

---
 rtl/axi_line_bridge_if.sv | 72 +++++++
 rtl/axi_line_bridge.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/axi_line_bridge_if.sv
// AXI4 master port of the cache-line bridge.
// The bridge drives the master modport; the memory side uses the slave modport.
interface axi_line_bridge_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic [1:0]      arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic [1:0]      awlock;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;

  logic [ID_W-1:0] wid;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_line_bridge.sv
// Cache-line bridge: 128-bit refills and writebacks become 4-beat AXI4 INCR bursts.
// Independent read and write FSMs share one AXI master port.
module axi_line_bridge #(
  parameter int ID_W  = 4,
  parameter int RD_ID = 0,
  parameter int WR_ID = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         rd_req,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic [127:0] ret_data,
  input  logic         wr_req,
  input  logic [31:0]  wr_addr,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic         wr_valid,
  axi_line_bridge_if.master axi
);

  typedef enum logic [2:0] {R_IDLE, R_HOLD, R_AR, R_DATA, R_RET} r_state_t;
  typedef enum logic [2:0] {W_IDLE, W_AW, W_DATA, W_B, W_DONE} w_state_t;

  r_state_t       r_state_reg, r_state_next;
  logic           rd_rdy_reg;
  logic [27:0]    r_line_reg;
  logic [1:0]     r_beat_reg;
  logic [31:0]    araddr_reg;
  logic [127:0]   ret_data_reg;
  logic [127:0]   r_line_data;
  logic           r_last_beat;
  logic           hazard;

  w_state_t       w_state_reg, w_state_next;
  logic           wr_rdy_reg;
  logic [27:0]    w_line_reg;
  logic [1:0]     w_beat_reg;
  logic [31:0]    awaddr_reg;
  logic [127:0]   w_data_reg;

  logic           unused_ok;
  assign unused_ok = ^{rd_addr[3:0], wr_addr[3:0], axi.rid, axi.rresp, axi.bid, axi.bresp};

  assign axi.arid    = ID_W'(RD_ID);
  assign axi.arlen   = 8'd3;
  assign axi.arsize  = 3'd2;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;
  assign axi.araddr  = araddr_reg;

  assign axi.awid    = ID_W'(WR_ID);
  assign axi.awlen   = 8'd3;
  assign axi.awsize  = 3'd2;
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'b0000;
  assign axi.awprot  = 3'b000;
  assign axi.awaddr  = awaddr_reg;

  assign axi.wid     = ID_W'(WR_ID);
  assign axi.wstrb   = 4'hF;
  assign axi.wdata   = w_data_reg[{w_beat_reg, 5'd0} +: 32];
  assign axi.wlast   = (w_beat_reg == 2'd3);

  assign rd_rdy   = rd_rdy_reg;
  assign wr_rdy   = wr_rdy_reg;
  assign ret_data = ret_data_reg;

  // A refill must not overtake a writeback of the same line still in flight.
  assign hazard      = (w_state_reg != W_IDLE) && (w_line_reg == r_line_reg);
  assign r_last_beat = axi.rvalid && (axi.rlast || r_beat_reg == 2'd3);

  // Collect beats per word; the beat in flight is merged so ret_data updates once, at the end.
  for (genvar gi = 0; gi < 4; gi++) begin : gen_rword
    logic [31:0] word_reg;
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
        word_reg <= 32'd0;
      else if (r_state_reg == R_DATA && axi.rvalid && r_beat_reg == 2'(gi))
        word_reg <= axi.rdata;
    end
    assign r_line_data[gi*32 +: 32] = (r_beat_reg == 2'(gi)) ? axi.rdata : word_reg;
  end

  always_comb begin
    r_state_next = r_state_reg;
    axi.arvalid  = 1'b0;
    axi.rready   = 1'b0;
    ret_valid    = 1'b0;
    case (r_state_reg)
      R_IDLE: if (rd_req && rd_rdy_reg) r_state_next = R_HOLD;
      R_HOLD: if (!hazard) r_state_next = R_AR;
      R_AR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) r_state_next = R_DATA;
      end
      R_DATA: begin
        axi.rready = 1'b1;
        if (r_last_beat) r_state_next = R_RET;
      end
      R_RET: begin
        ret_valid    = 1'b1;
        r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_reg  <= R_IDLE;
      rd_rdy_reg   <= 1'b0;
      r_line_reg   <= 28'd0;
      r_beat_reg   <= 2'd0;
      araddr_reg   <= 32'd0;
      ret_data_reg <= 128'd0;
    end else begin
      r_state_reg <= r_state_next;
      rd_rdy_reg  <= (r_state_next == R_IDLE);
      if (r_state_reg == R_IDLE && rd_req && rd_rdy_reg)
        r_line_reg <= rd_addr[31:4];
      if (r_state_reg == R_HOLD && !hazard)
        araddr_reg <= {r_line_reg, 4'b0000};
      if (r_state_reg == R_AR && axi.arready)
        r_beat_reg <= 2'd0;
      if (r_state_reg == R_DATA && axi.rvalid) begin
        r_beat_reg <= r_beat_reg + 2'd1;
        if (r_last_beat) ret_data_reg <= r_line_data;
      end
    end
  end

  always_comb begin
    w_state_next = w_state_reg;
    axi.awvalid  = 1'b0;
    axi.wvalid   = 1'b0;
    axi.bready   = 1'b0;
    wr_valid     = 1'b0;
    case (w_state_reg)
      W_IDLE: if (wr_req && wr_rdy_reg) w_state_next = W_AW;
      W_AW: begin
        axi.awvalid = 1'b1;
        if (axi.awready) w_state_next = W_DATA;
      end
      W_DATA: begin
        axi.wvalid = 1'b1;
        if (axi.wready && w_beat_reg == 2'd3) w_state_next = W_B;
      end
      W_B: begin
        axi.bready = 1'b1;
        if (axi.bvalid) w_state_next = W_DONE;
      end
      W_DONE: begin
        wr_valid     = 1'b1;
        w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state_reg <= W_IDLE;
      wr_rdy_reg  <= 1'b0;
      w_line_reg  <= 28'd0;
      w_beat_reg  <= 2'd0;
      awaddr_reg  <= 32'd0;
      w_data_reg  <= 128'd0;
    end else begin
      w_state_reg <= w_state_next;
      wr_rdy_reg  <= (w_state_next == W_IDLE);
      if (w_state_reg == W_IDLE && wr_req && wr_rdy_reg) begin
        w_line_reg <= wr_addr[31:4];
        awaddr_reg <= {wr_addr[31:4], 4'b0000};
        w_data_reg <= wr_data;
      end
      if (w_state_reg == W_AW && axi.awready)
        w_beat_reg <= 2'd0;
      if (w_state_reg == W_DATA && axi.wready)
        w_beat_reg <= w_beat_reg + 2'd1;
    end
  end

endmodule
